// File: rtl/key_debounce.sv
// Debounces NUM_KEYS active-low push buttons into clean levels plus press/release strobes.
// Define KEY_LONG_PRESS_EN to add the per-key long-press strobe (key_long) and LONG_MAX.
module key_debounce #(
  parameter int unsigned NUM_KEYS = 4,
  parameter logic [31:0] CNT_MAX  = 32'd500_000
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter logic [31:0] LONG_MAX = 32'd50_000_000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic [NUM_KEYS-1:0] key_long
`endif
);

  // One fully independent lane per key; vector ports split one bit per instance.
  key_debounce_lane #(
    .CNT_MAX  (CNT_MAX)
`ifdef KEY_LONG_PRESS_EN
    ,
    .LONG_MAX (LONG_MAX)
`endif
  ) u_lane [NUM_KEYS-1:0] (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .level (key_level),
    .press (key_press),
    .rel   (key_release)
`ifdef KEY_LONG_PRESS_EN
    ,
    .long_p(key_long)
`endif
  );

endmodule

// Single key: 2-flop synchroniser, debounce FSM with stability counter, optional hold timer.
module key_debounce_lane #(
  parameter logic [31:0] CNT_MAX  = 32'd500_000
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter logic [31:0] LONG_MAX = 32'd50_000_000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic long_p
`endif
);

  typedef enum logic [1:0] {IDLE, P_WAIT, PRESSED, R_WAIT} state_t;

  state_t      state;
  logic [1:0]  sync_ff;
  logic        sync;
  logic [31:0] cnt;
  logic        cnt_done;

  // Flops hold the raw active-low level, so reset to 1 means "released".
  always_ff @(posedge clk) begin
    if (reset) sync_ff <= 2'b11;
    else       sync_ff <= {sync_ff[0], key_n};
  end

  assign sync     = ~sync_ff[1];
  assign cnt_done = (cnt == CNT_MAX - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= P_WAIT;
            cnt   <= '0;
          end
        end
        P_WAIT: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= PRESSED;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        PRESSED: begin
          if (!sync) begin
            state <= R_WAIT;
            cnt   <= '0;
          end
        end
        R_WAIT: begin
          if (sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  logic [31:0] hcnt;
  logic        long_done;

  // Held in reset while not pressed, so it is zero on the cycle PRESSED is entered;
  // keeps running through R_WAIT so release bounces do not restart the hold time.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt      <= '0;
      long_done <= 1'b0;
      long_p    <= 1'b0;
    end else begin
      long_p <= 1'b0;
      if (state == IDLE || state == P_WAIT) begin
        hcnt      <= '0;
        long_done <= 1'b0;
      end else if (hcnt == LONG_MAX - 32'd1) begin
        if (!long_done) begin
          long_p    <= 1'b1;
          long_done <= 1'b1;
        end
      end else begin
        hcnt <= hcnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed scenarios plus random bouncing keys, checked every cycle against a run-length model.
module tb_key_debounce;
  localparam int NK   = 4;
  localparam int CNT  = 8;
  localparam int LONG = 32;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level, key_press, key_release;
`ifdef KEY_LONG_PRESS_EN
  logic [NK-1:0] key_long;
`endif

  int checks = 0;
  int errors = 0;

  // Model: a key level is accepted once the synchronised input has shown it for CNT+1 samples.
  logic [NK-1:0] kd0 = '1, kd1 = '1, lastobs = '0;
  logic [NK-1:0] lvl_m = '0, prs_m = '0, rel_m = '0, lng_m = '0;
  int run_m [NK];
  int ptime [NK];
  int cyc = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS (NK),
    .CNT_MAX  (32'd8)
`ifdef KEY_LONG_PRESS_EN
    ,
    .LONG_MAX (32'd32)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
`ifdef KEY_LONG_PRESS_EN
    ,
    .key_long   (key_long)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model(input logic [NK-1:0] kn, input logic rst);
    logic [NK-1:0] obs;
    cyc++;
    prs_m = '0;
    rel_m = '0;
    lng_m = '0;
    if (rst) begin
      kd0 = '1; kd1 = '1; lvl_m = '0; lastobs = '0;
      for (int k = 0; k < NK; k++) run_m[k] = 0;
    end else begin
      obs = ~kd1;
      kd1 = kd0;
      kd0 = kn;
      for (int k = 0; k < NK; k++) begin
        run_m[k]   = (obs[k] == lastobs[k]) ? run_m[k] + 1 : 1;
        lastobs[k] = obs[k];
        if (lvl_m[k] && (cyc - ptime[k] == LONG)) lng_m[k] = 1'b1;
        if (obs[k] != lvl_m[k] && run_m[k] >= CNT + 1) begin
          lvl_m[k] = obs[k];
          if (obs[k]) begin
            prs_m[k] = 1'b1;
            ptime[k] = cyc;
          end else begin
            rel_m[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step(input logic [NK-1:0] kn, input logic rst);
    @(negedge clk);
    key_n = kn;
    reset = rst;
    @(posedge clk);
    model(kn, rst);
    #1;
    chk("level",   {28'd0, key_level},   {28'd0, lvl_m});
    chk("press",   {28'd0, key_press},   {28'd0, prs_m});
    chk("release", {28'd0, key_release}, {28'd0, rel_m});
`ifdef KEY_LONG_PRESS_EN
    chk("long",    {28'd0, key_long},    {28'd0, lng_m});
`endif
  endtask

  initial begin
    logic [NK-1:0] kn;
    int p_idx, p_cnt, r_idx, r_cnt, p2, p3;
    int hold [NK];

    // Reset, then idle: everything must stay low.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
    for (int i = 0; i < 50; i++) step(4'b1111, 1'b0);

    // Key 0 pressed: single press pulse 10 cycles after the sampling edge.
    p_idx = -1; p_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(4'b1110, 1'b0);
      if (key_press[0]) begin p_cnt++; if (p_idx < 0) p_idx = i; end
    end
    chk("press0_latency", p_idx, 10);
    chk("press0_count", p_cnt, 1);

    // Key 1 chatters every 3 cycles: must be rejected entirely.
    p_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      kn = 4'b1110;
      kn[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step(kn, 1'b0);
      if (key_press[1] || key_release[1] || key_level[1]) p_cnt++;
    end
    for (int i = 0; i < 12; i++) step(4'b1110, 1'b0);
    chk("chatter1_events", p_cnt, 0);

    // 5-cycle release glitch on held key 0: no release.
    r_cnt = 0;
    for (int i = 0; i < 5; i++) begin step(4'b1111, 1'b0); if (key_release[0]) r_cnt++; end
    for (int i = 0; i < 15; i++) begin step(4'b1110, 1'b0); if (key_release[0]) r_cnt++; end
    chk("glitch0_release", r_cnt, 0);
    chk("glitch0_level", {31'd0, key_level[0]}, 32'd1);

    // Real release of key 0.
    r_idx = -1; r_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(4'b1111, 1'b0);
      if (key_release[0]) begin r_cnt++; if (r_idx < 0) r_idx = i; end
    end
    chk("release0_latency", r_idx, 10);
    chk("release0_count", r_cnt, 1);

    // Keys 2 and 3 together.
    p2 = -1; p3 = -1;
    for (int i = 0; i < 14; i++) begin
      step(4'b0011, 1'b0);
      if (key_press[2] && p2 < 0) p2 = i;
      if (key_press[3] && p3 < 0) p3 = i;
    end
    chk("press2_latency", p2, 10);
    chk("press3_latency", p3, 10);
    for (int i = 0; i < 14; i++) step(4'b1111, 1'b0);

    // Long hold of key 0.
    p_idx = -1; r_idx = -1; r_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(4'b1110, 1'b0);
      if (key_press[0] && p_idx < 0) p_idx = i;
`ifdef KEY_LONG_PRESS_EN
      if (key_long[0]) begin r_cnt++; if (r_idx < 0) r_idx = i; end
`endif
    end
    chk("hold0_press_latency", p_idx, 10);
`ifdef KEY_LONG_PRESS_EN
    chk("long0_after_press", r_idx - p_idx, LONG);
    chk("long0_count", r_cnt, 1);
`endif

    // Reset while held: re-accepted as a fresh press 10 cycles after reset drops.
    for (int i = 0; i < 3; i++) step(4'b1110, 1'b1);
    chk("reset_level", {28'd0, key_level}, 32'd0);
    p_idx = -1;
    for (int i = 0; i < 14; i++) begin
      step(4'b1110, 1'b0);
      if (key_press[0] && p_idx < 0) p_idx = i;
    end
    chk("reset_repress_latency", p_idx, 10);

    // Random bouncing on all keys with occasional reset pulses.
    kn = 4'b1110;
    for (int k = 0; k < NK; k++) hold[k] = 1;
    for (int i = 0; i < 900; i++) begin
      for (int k = 0; k < NK; k++) begin
        hold[k]--;
        if (hold[k] == 0) begin
          kn[k] = ~kn[k];
          hold[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7))
                                                : int'($urandom_range(9, 45));
        end
      end
      step(kn, $urandom_range(0, 249) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
